// File: rtl/multi_rate_counter_if.sv
// multi_rate_counter_if: control, configuration and status bus of multi_rate_counter
//   clock_enable                                  global advance strobe
//   cfg_wr, cfg_ch, cfg_div, cfg_limit, cfg_oneshot  per-channel config write
//   start, clear                                  per-channel control pulses
//   count, tick, wrap, busy                       per-channel registered status
interface multi_rate_counter_if #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 12,
    parameter int PRE_W  = 8,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic                    clock_enable;
    logic                    cfg_wr;
    logic [CH_W-1:0]         cfg_ch;
    logic [PRE_W-1:0]        cfg_div;
    logic [WIDTH-1:0]        cfg_limit;
    logic                    cfg_oneshot;
    logic [NUM_CH-1:0]       start;
    logic [NUM_CH-1:0]       clear;
    logic [NUM_CH*WIDTH-1:0] count;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH-1:0]       wrap;
    logic [NUM_CH-1:0]       busy;

    modport master (
        output clock_enable, cfg_wr, cfg_ch, cfg_div, cfg_limit, cfg_oneshot, start, clear,
        input  count, tick, wrap, busy
    );
    modport slave (
        input  clock_enable, cfg_wr, cfg_ch, cfg_div, cfg_limit, cfg_oneshot, start, clear,
        output count, tick, wrap, busy
    );
endinterface

// File: rtl/multi_rate_counter.sv
// multi_rate_counter: NUM_CH prescaled counters with programmable divide, limit and wrap/one-shot mode
//   clock    system clock
//   reset_n  synchronous, active-low reset
//   bus      multi_rate_counter_if slave: clock_enable, cfg_*, start, clear in; count, tick, wrap, busy out
module multi_rate_counter #(
    parameter int NUM_CH      = 4,
    parameter int WIDTH       = 12,
    parameter int PRE_W       = 8,
    parameter int DEFAULT_DIV = 1
) (
    input logic                 clock,
    input logic                 reset_n,
    multi_rate_counter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t           state_q, state_d;
        logic [PRE_W-1:0] pre_q, pre_d, div_q, div_d, div_m1;
        logic [WIDTH-1:0] cnt_q, cnt_d, lim_q, lim_d;
        logic             os_q, os_d, tick_q, tick_d, wrap_q, wrap_d;
        logic             hit, step, at_lim;

        always_ff @(posedge clock) begin
            if (!reset_n) begin
                state_q <= IDLE;
                pre_q   <= '0;
                cnt_q   <= '0;
                div_q   <= PRE_W'(DEFAULT_DIV);
                lim_q   <= '1;
                os_q    <= 1'b0;
                tick_q  <= 1'b0;
                wrap_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                pre_q   <= pre_d;
                cnt_q   <= cnt_d;
                div_q   <= div_d;
                lim_q   <= lim_d;
                os_q    <= os_d;
                tick_q  <= tick_d;
                wrap_q  <= wrap_d;
            end
        end

        assign hit    = bus.cfg_wr && (int'(bus.cfg_ch) == i);
        assign div_m1 = (div_q == '0) ? '0 : div_q - 1'b1;
        // >= rather than == so a divide factor lowered below the running prescale fires next step
        assign step   = (state_q == RUN) && bus.clock_enable && (pre_q >= div_m1);
        assign at_lim = cnt_q >= lim_q;

        always_comb begin
            div_d   = hit ? bus.cfg_div : div_q;
            lim_d   = hit ? bus.cfg_limit : lim_q;
            os_d    = hit ? bus.cfg_oneshot : os_q;
            state_d = state_q;
            pre_d   = pre_q;
            cnt_d   = cnt_q;
            tick_d  = 1'b0;
            wrap_d  = 1'b0;
            if (bus.clear[i]) begin
                state_d = IDLE;
                pre_d   = '0;
                cnt_d   = '0;
            end else if (bus.start[i]) begin
                state_d = RUN;
                pre_d   = '0;
                cnt_d   = '0;
            end else if (step) begin
                pre_d   = '0;
                tick_d  = 1'b1;
                wrap_d  = at_lim;
                cnt_d   = at_lim ? (os_q ? cnt_q : '0) : cnt_q + 1'b1;
                state_d = (at_lim && os_q) ? DONE : RUN;
            end else if (state_q == RUN && bus.clock_enable) begin
                pre_d   = pre_q + 1'b1;
            end
        end

        assign bus.count[i*WIDTH +: WIDTH] = cnt_q;
        assign bus.tick[i] = tick_q;
        assign bus.wrap[i] = wrap_q;
        assign bus.busy[i] = state_q == RUN;
    end
endmodule

// File: tb/tb_multi_rate_counter.sv
// tb_multi_rate_counter: directed and randomized checks of multi_rate_counter against a cycle model
module tb_multi_rate_counter;
    localparam int N  = 4;
    localparam int W  = 12;
    localparam int P  = 8;
    localparam int CW = 2;
    localparam int DEF_DIV = 1;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    multi_rate_counter_if #(.NUM_CH(N), .WIDTH(W), .PRE_W(P)) bus ();
    multi_rate_counter #(.NUM_CH(N), .WIDTH(W), .PRE_W(P), .DEFAULT_DIV(DEF_DIV)) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus));

    multi_rate_counter_if #(.NUM_CH(3), .WIDTH(W), .PRE_W(P)) bus3 ();
    multi_rate_counter #(.NUM_CH(3), .WIDTH(W), .PRE_W(P), .DEFAULT_DIV(DEF_DIV)) dut3 (
        .clock(clock), .reset_n(reset_n), .bus(bus3));

    always #5 clock = ~clock;

    // Reference model: 0 idle, 1 running, 2 done; prescaler counts enabled cycles up to div
    int m_st [N];
    int m_pre[N];
    int m_cnt[N];
    int m_div[N];
    int m_lim[N];
    int m_os [N];
    bit m_tick[N];
    bit m_wrap[N];

    task automatic model_edge();
        int d, nd, nl, no;
        for (int c = 0; c < N; c++) begin
            m_tick[c] = 1'b0;
            m_wrap[c] = 1'b0;
            if (!reset_n) begin
                m_st[c] = 0; m_pre[c] = 0; m_cnt[c] = 0;
                m_div[c] = DEF_DIV; m_lim[c] = (1 << W) - 1; m_os[c] = 0;
                continue;
            end
            d  = (m_div[c] == 0) ? 1 : m_div[c];
            nd = m_div[c]; nl = m_lim[c]; no = m_os[c];
            if (bus.cfg_wr && int'(bus.cfg_ch) == c) begin
                nd = int'(bus.cfg_div); nl = int'(bus.cfg_limit); no = int'(bus.cfg_oneshot);
            end
            if (bus.clear[c]) begin
                m_st[c] = 0; m_pre[c] = 0; m_cnt[c] = 0;
            end else if (bus.start[c]) begin
                m_st[c] = 1; m_pre[c] = 0; m_cnt[c] = 0;
            end else if (m_st[c] == 1 && bus.clock_enable) begin
                m_pre[c]++;
                if (m_pre[c] >= d) begin
                    m_pre[c] = 0;
                    m_tick[c] = 1'b1;
                    if (m_cnt[c] >= m_lim[c]) begin
                        m_wrap[c] = 1'b1;
                        if (m_os[c] != 0) m_st[c] = 2;
                        else m_cnt[c] = 0;
                    end else m_cnt[c]++;
                end
            end
            m_div[c] = nd; m_lim[c] = nl; m_os[c] = no;
        end
    endtask

    function automatic logic [N*W+3*N-1:0] exp_all();
        logic [N*W-1:0] c;
        logic [N-1:0]   t, w, b;
        for (int i = 0; i < N; i++) begin
            c[i*W +: W] = W'(m_cnt[i]);
            t[i] = m_tick[i];
            w[i] = m_wrap[i];
            b[i] = m_st[i] == 1;
        end
        return {c, t, w, b};
    endfunction

    task automatic cyc();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic cfg(input int ch, input int dv, input int lim, input bit os);
        bus.cfg_wr = 1'b1;
        bus.cfg_ch = CW'(ch);
        bus.cfg_div = P'(dv);
        bus.cfg_limit = W'(lim);
        bus.cfg_oneshot = os;
        cyc();
        bus.cfg_wr = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cyc();
        cyc();
        tests++;
        if ({bus.count, bus.tick, bus.wrap, bus.busy} !== '0) begin
            fails++;
            $display("FAIL reset_outputs got %h required 0", {bus.count, bus.tick, bus.wrap, bus.busy});
        end
        tests++;
        if ({bus.count, bus.tick, bus.wrap, bus.busy} !== exp_all()) begin
            fails++;
            $display("FAIL reset_model got %h required %h", {bus.count, bus.tick, bus.wrap, bus.busy}, exp_all());
        end
        reset_n = 1'b1;
    endtask

    task automatic test_wrap_div4();
        cfg(0, 4, 2, 0);
        bus.clock_enable = 1'b1;
        bus.start = 4'b0001;
        cyc();
        bus.start = '0;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            tests++;
            if (bus.count[0 +: W] !== W'((k / 4) % 3) || bus.tick[0] !== (k % 4 == 0) || bus.wrap[0] !== (k == 12)) begin
                fails++;
                $display("FAIL wrap_div4 k=%0d got cnt=%0d tick=%b wrap=%b required cnt=%0d tick=%b wrap=%b",
                         k, bus.count[0 +: W], bus.tick[0], bus.wrap[0], (k / 4) % 3, k % 4 == 0, k == 12);
            end
            tests++;
            if ({bus.count, bus.tick, bus.wrap, bus.busy} !== exp_all()) begin
                fails++;
                $display("FAIL wrap_div4_model got %h required %h", {bus.count, bus.tick, bus.wrap, bus.busy}, exp_all());
            end
        end
    endtask

    task automatic test_oneshot();
        int e;
        cfg(1, 3, 5, 1);
        bus.start = 4'b0010;
        cyc();
        bus.start = '0;
        for (int k = 1; k <= 68; k++) begin
            cyc();
            e = (k / 3 > 5) ? 5 : k / 3;
            tests++;
            if (bus.count[W +: W] !== W'(e) || bus.wrap[1] !== (k == 18) || bus.busy[1] !== (k < 18)) begin
                fails++;
                $display("FAIL oneshot k=%0d got cnt=%0d wrap=%b busy=%b required cnt=%0d wrap=%b busy=%b",
                         k, bus.count[W +: W], bus.wrap[1], bus.busy[1], e, k == 18, k < 18);
            end
        end
        bus.start = 4'b0010;
        cyc();
        bus.start = '0;
        tests++;
        if (bus.count[W +: W] !== '0 || bus.busy[1] !== 1'b1) begin
            fails++;
            $display("FAIL oneshot_restart got cnt=%0d busy=%b required cnt=0 busy=1", bus.count[W +: W], bus.busy[1]);
        end
        tests++;
        if ({bus.count, bus.tick, bus.wrap, bus.busy} !== exp_all()) begin
            fails++;
            $display("FAIL oneshot_model got %h required %h", {bus.count, bus.tick, bus.wrap, bus.busy}, exp_all());
        end
    endtask

    task automatic test_div01_enable();
        int n;
        for (int dv = 0; dv < 2; dv++) begin
            cfg(2, dv, 100, 0);
            bus.start = 4'b0100;
            cyc();
            bus.start = '0;
            n = 0;
            for (int k = 0; k < 20; k++) begin
                bus.clock_enable = (k % 2 == 0);
                cyc();
                if (k % 2 == 0) n++;
                tests++;
                if (bus.tick[2] !== (k % 2 == 0) || bus.count[2*W +: W] !== W'(n)) begin
                    fails++;
                    $display("FAIL div%0d_enable k=%0d got tick=%b cnt=%0d required tick=%b cnt=%0d",
                             dv, k, bus.tick[2], bus.count[2*W +: W], k % 2 == 0, n);
                end
                tests++;
                if ({bus.count, bus.tick, bus.wrap, bus.busy} !== exp_all()) begin
                    fails++;
                    $display("FAIL div_enable_model got %h required %h", {bus.count, bus.tick, bus.wrap, bus.busy}, exp_all());
                end
            end
        end
        bus.clock_enable = 1'b1;
    endtask

    task automatic test_reset_midcount();
        cfg(0, 4, 9, 0);
        bus.start = 4'b0001;
        cyc();
        bus.start = '0;
        for (int k = 0; k < 6; k++) cyc();
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        tests++;
        if ({bus.count, bus.tick, bus.wrap, bus.busy} !== '0) begin
            fails++;
            $display("FAIL midcount_reset got %h required 0", {bus.count, bus.tick, bus.wrap, bus.busy});
        end
        bus.start = 4'b0001;
        cyc();
        bus.start = '0;
        cyc();
        tests++;
        if (bus.count[0 +: W] !== W'(1) || bus.tick[0] !== 1'b1) begin
            fails++;
            $display("FAIL default_div got cnt=%0d tick=%b required cnt=1 tick=1", bus.count[0 +: W], bus.tick[0]);
        end
        cyc();
        cyc();
        bus.start = 4'b0001;
        bus.clear = 4'b0001;
        cyc();
        bus.start = '0;
        bus.clear = '0;
        cyc();
        tests++;
        if (bus.count[0 +: W] !== '0 || bus.busy[0] !== 1'b0 || bus.tick[0] !== 1'b0) begin
            fails++;
            $display("FAIL clear_wins got cnt=%0d busy=%b tick=%b required 0 0 0", bus.count[0 +: W], bus.busy[0], bus.tick[0]);
        end
        tests++;
        if ({bus.count, bus.tick, bus.wrap, bus.busy} !== exp_all()) begin
            fails++;
            $display("FAIL midcount_model got %h required %h", {bus.count, bus.tick, bus.wrap, bus.busy}, exp_all());
        end
    endtask

    task automatic test_cfg_live();
        cfg(0, 4, 2, 0);
        cfg(3, 1, 100, 0);
        bus.clock_enable = 1'b1;
        bus.start = 4'b1001;
        cyc();
        bus.start = '0;
        for (int k = 0; k < 7; k++) cyc();
        tests++;
        if (bus.count[3*W +: W] !== W'(7)) begin
            fails++;
            $display("FAIL cfg_live_pre got cnt=%0d required 7", bus.count[3*W +: W]);
        end
        bus.clock_enable = 1'b0;
        cfg(3, 1, 1, 0);
        bus.clock_enable = 1'b1;
        cyc();
        tests++;
        if (bus.count[3*W +: W] !== '0 || bus.wrap[3] !== 1'b1) begin
            fails++;
            $display("FAIL cfg_live_wrap got cnt=%0d wrap=%b required cnt=0 wrap=1", bus.count[3*W +: W], bus.wrap[3]);
        end
        for (int k = 0; k < 12; k++) begin
            cyc();
            tests++;
            if ({bus.count, bus.tick, bus.wrap, bus.busy} !== exp_all()) begin
                fails++;
                $display("FAIL cfg_live_model got %h required %h", {bus.count, bus.tick, bus.wrap, bus.busy}, exp_all());
            end
        end
    endtask

    task automatic test_invalid_ch();
        bus3.cfg_wr = 1'b1;
        bus3.cfg_ch = 2'd3;
        bus3.cfg_div = P'(5);
        bus3.cfg_limit = '0;
        bus3.cfg_oneshot = 1'b1;
        cyc();
        bus3.cfg_wr = 1'b0;
        bus3.clock_enable = 1'b1;
        bus3.start = 3'b111;
        cyc();
        bus3.start = '0;
        for (int k = 0; k < 3; k++) cyc();
        tests++;
        if (bus3.count !== {3{W'(3)}} || bus3.wrap !== 3'b000 || bus3.busy !== 3'b111) begin
            fails++;
            $display("FAIL invalid_ch got cnt=%h wrap=%b busy=%b required cnt=%h wrap=000 busy=111",
                     bus3.count, bus3.wrap, bus3.busy, {3{W'(3)}});
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            reset_n = $urandom_range(0, 299) != 0;
            bus.clock_enable = $urandom_range(0, 3) != 0;
            bus.cfg_wr = $urandom_range(0, 7) == 0;
            bus.cfg_ch = CW'($urandom_range(0, N - 1));
            bus.cfg_div = P'($urandom_range(0, 3));
            bus.cfg_limit = W'($urandom_range(0, 6));
            bus.cfg_oneshot = $urandom_range(0, 1) != 0;
            for (int c = 0; c < N; c++) begin
                bus.start[c] = $urandom_range(0, 9) == 0;
                bus.clear[c] = $urandom_range(0, 24) == 0;
            end
            cyc();
            tests++;
            if ({bus.count, bus.tick, bus.wrap, bus.busy} !== exp_all()) begin
                fails++;
                $display("FAIL random k=%0d got %h required %h", k, {bus.count, bus.tick, bus.wrap, bus.busy}, exp_all());
            end
        end
        reset_n = 1'b1;
        bus.cfg_wr = 1'b0;
        bus.start = '0;
        bus.clear = '0;
    endtask

    initial begin
        bus.clock_enable = 1'b0;
        bus.cfg_wr = 1'b0;
        bus.cfg_ch = '0;
        bus.cfg_div = '0;
        bus.cfg_limit = '0;
        bus.cfg_oneshot = 1'b0;
        bus.start = '0;
        bus.clear = '0;
        bus3.clock_enable = 1'b0;
        bus3.cfg_wr = 1'b0;
        bus3.cfg_ch = '0;
        bus3.cfg_div = '0;
        bus3.cfg_limit = '0;
        bus3.cfg_oneshot = 1'b0;
        bus3.start = '0;
        bus3.clear = '0;
        test_reset();
        test_wrap_div4();
        test_oneshot();
        test_div01_enable();
        test_reset_midcount();
        test_cfg_live();
        test_invalid_ch();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
